// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low hex glyphs, blank/zero codes,
// and the direction/mode encodings used by the counter.
package seg7_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_ZERO  = 8'h03;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    typedef enum logic {
        MODE_SAT  = 1'b0,
        MODE_WRAP = 1'b1
    } mode_e;

    // Segment order is {a,b,c,d,e,f,g,dp}; a 0 lights the segment, dp stays dark.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] nibble);
        logic [7:0] seg;
        case (nibble)
            4'h0:    seg = 8'b0000_0011;
            4'h1:    seg = 8'b1001_1111;
            4'h2:    seg = 8'b0010_0101;
            4'h3:    seg = 8'b0000_1101;
            4'h4:    seg = 8'b1001_1001;
            4'h5:    seg = 8'b0100_1001;
            4'h6:    seg = 8'b0100_0001;
            4'h7:    seg = 8'b0001_1111;
            4'h8:    seg = 8'b0000_0001;
            4'h9:    seg = 8'b0000_1001;
            4'hA:    seg = 8'b0001_0001;
            4'hB:    seg = 8'b1100_0001;
            4'hC:    seg = 8'b0110_0011;
            4'hD:    seg = 8'b1000_0101;
            4'hE:    seg = 8'b0110_0001;
            4'hF:    seg = 8'b0111_0001;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational hex-to-segment decoder for one nibble.
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [7:0] seg_o
);

    // Translate the selected nibble into its active-low glyph.
    always_comb begin
        seg_o = hex_to_seg(nibble_i);
    end

endmodule

// File: rtl/scan_updown_counter.sv
// Prescaled up/down counter with wrap/saturate and parallel load, shown in hex
// on a multiplexed seven-segment display.
module scan_updown_counter
    import seg7_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int NUM_DIGITS = WIDTH / 4,
    parameter int TICK_DIV   = 25_000_000,
    parameter int SCAN_DIV   = 100_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  up,
    input  logic                  wrap,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    output logic [WIDTH-1:0]      count,
    output logic                  tc,
    output logic [7:0]            display,
    output logic [NUM_DIGITS-1:0] ctrl
);

    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [WIDTH-1:0]      CNT_MAX   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]      CNT_ZERO  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]      CNT_ONE   = WIDTH'(1);
    localparam logic [TICK_W-1:0]     TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [TICK_W-1:0]     TICK_ONE  = TICK_W'(1);
    localparam logic [TICK_W-1:0]     TICK_ZERO = {TICK_W{1'b0}};
    localparam logic [SCAN_W-1:0]     SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [SCAN_W-1:0]     SCAN_ONE  = SCAN_W'(1);
    localparam logic [SCAN_W-1:0]     SCAN_ZERO = {SCAN_W{1'b0}};
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [IDX_W-1:0]      IDX_ONE   = IDX_W'(1);
    localparam logic [IDX_W-1:0]      IDX_ZERO  = {IDX_W{1'b0}};
    localparam logic [NUM_DIGITS-1:0] CTRL_ONE  = NUM_DIGITS'(1);

    logic [TICK_W-1:0]     presc_q,   presc_d;
    logic [WIDTH-1:0]      count_q,   count_d;
    logic                  tc_q,      tc_d;
    logic [SCAN_W-1:0]     scan_q,    scan_d;
    logic [IDX_W-1:0]      idx_q,     idx_d;
    logic [7:0]            display_q, display_d;
    logic [NUM_DIGITS-1:0] ctrl_q,    ctrl_d;

    logic                  tick_s;
    dir_e                  dir_s;
    mode_e                 mode_s;
    logic [WIDTH-1:0]      shifted_s;
    logic [3:0]            nibble_s;
    logic [7:0]            seg_s;

    assign tick_s = (presc_q == TICK_LAST);
    assign dir_s  = dir_e'(up);
    assign mode_s = mode_e'(wrap);

    // Prescaler and count step; load wins over a tick and restarts the prescaler.
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        presc_d = tick_s ? TICK_ZERO : (presc_q + TICK_ONE);
        if (load) begin
            count_d = load_val;
            presc_d = TICK_ZERO;
        end else if (tick_s && en) begin
            // tc flags any step attempted from the boundary, wrapping or not.
            case (dir_s)
                DIR_UP: begin
                    if (count_q == CNT_MAX) begin
                        tc_d    = 1'b1;
                        count_d = (mode_s == MODE_WRAP) ? CNT_ZERO : CNT_MAX;
                    end else begin
                        count_d = count_q + CNT_ONE;
                    end
                end
                DIR_DOWN: begin
                    if (count_q == CNT_ZERO) begin
                        tc_d    = 1'b1;
                        count_d = (mode_s == MODE_WRAP) ? CNT_MAX : CNT_ZERO;
                    end else begin
                        count_d = count_q - CNT_ONE;
                    end
                end
                default: count_d = count_q;
            endcase
        end else begin
            count_d = count_q;
        end
    end

    // Scan divider and digit index.
    always_comb begin
        scan_d = scan_q;
        idx_d  = idx_q;
        if (scan_q == SCAN_LAST) begin
            scan_d = SCAN_ZERO;
            if (idx_q == IDX_LAST) begin
                idx_d = IDX_ZERO;
            end else begin
                idx_d = idx_q + IDX_ONE;
            end
        end else begin
            scan_d = scan_q + SCAN_ONE;
        end
    end

    assign shifted_s = count_q >> {idx_q, 2'b00};
    assign nibble_s  = shifted_s[3:0];

    seg7_decoder u_dec (
        .nibble_i (nibble_s),
        .seg_o    (seg_s)
    );

    // Glyph and digit select both come from idx_q so they always name the same digit.
    always_comb begin
        display_d = seg_s;
        ctrl_d    = ~(CTRL_ONE << idx_q);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q   <= TICK_ZERO;
            count_q   <= CNT_ZERO;
            tc_q      <= 1'b0;
            scan_q    <= SCAN_ZERO;
            idx_q     <= IDX_ZERO;
            display_q <= SEG_ZERO;
            ctrl_q    <= ~CTRL_ONE;
        end else begin
            presc_q   <= presc_d;
            count_q   <= count_d;
            tc_q      <= tc_d;
            scan_q    <= scan_d;
            idx_q     <= idx_d;
            display_q <= display_d;
            ctrl_q    <= ctrl_d;
        end
    end

    assign count   = count_q;
    assign tc      = tc_q;
    assign display = display_q;
    assign ctrl    = ctrl_q;

endmodule

// File: tb/tb_scan_updown_counter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// cycle-level integer reference model of the counter and display scan.
module tb_scan_updown_counter;

    localparam int WIDTH      = 8;
    localparam int NUM_DIGITS = 2;
    localparam int TICK_DIV   = 4;
    localparam int SCAN_DIV   = 2;
    localparam int MAXV       = 255;

    logic                  clk;
    logic                  rst_n;
    logic                  en;
    logic                  up;
    logic                  wrap;
    logic                  load;
    logic [WIDTH-1:0]      load_val;
    logic [WIDTH-1:0]      count;
    logic                  tc;
    logic [7:0]            display;
    logic [NUM_DIGITS-1:0] ctrl;

    int n_checks;
    int n_fail;

    // Reference model state (plain integers).
    int m_count;
    int m_tc;
    int m_presc;
    int m_scan;
    int m_idx;
    int m_disp;
    int m_ctrl;

    logic [7:0] seg_ref [16];

    scan_updown_counter #(
        .WIDTH      (WIDTH),
        .NUM_DIGITS (NUM_DIGITS),
        .TICK_DIV   (TICK_DIV),
        .SCAN_DIV   (SCAN_DIV)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .up       (up),
        .wrap     (wrap),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .tc       (tc),
        .display  (display),
        .ctrl     (ctrl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s obs=0x%0h exp=0x%0h @%0t", tag, obs, exp_v, $time);
        end
    endtask

    // Advance the model by one rising edge using the inputs currently applied.
    task automatic model_edge();
        int tick;
        if (!rst_n) begin
            m_count = 0; m_tc = 0; m_presc = 0; m_scan = 0; m_idx = 0;
            m_disp  = 8'h03;
            m_ctrl  = 2'b10;
        end else begin
            m_disp = seg_ref[(m_count >> (4 * m_idx)) & 15];
            m_ctrl = (~(1 << m_idx)) & 3;
            if (m_scan == SCAN_DIV - 1) begin
                m_scan = 0;
                m_idx  = (m_idx + 1) % NUM_DIGITS;
            end else begin
                m_scan = m_scan + 1;
            end
            tick = (m_presc == TICK_DIV - 1) ? 1 : 0;
            m_tc = 0;
            if (load) begin
                m_count = int'(load_val);
                m_presc = 0;
            end else begin
                m_presc = (m_presc + 1) % TICK_DIV;
                if (tick == 1 && en) begin
                    if (up) begin
                        if (m_count == MAXV) begin
                            m_tc    = 1;
                            m_count = wrap ? 0 : MAXV;
                        end else begin
                            m_count = m_count + 1;
                        end
                    end else begin
                        if (m_count == 0) begin
                            m_tc    = 1;
                            m_count = wrap ? MAXV : 0;
                        end else begin
                            m_count = m_count - 1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_eq("count",   32'(count),   32'(m_count));
        check_eq("tc",      32'(tc),      32'(m_tc));
        check_eq("display", 32'(display), 32'(m_disp));
        check_eq("ctrl",    32'(ctrl),    32'(m_ctrl));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        logic [7:0] pick [5];
        n_checks = 0;
        n_fail   = 0;
        seg_ref  = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                     8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};
        m_count = 0; m_tc = 0; m_presc = 0; m_scan = 0; m_idx = 0;
        m_disp = 8'h03; m_ctrl = 2'b10;

        rst_n = 1'b0; en = 1'b1; up = 1'b1; wrap = 1'b1; load = 1'b0; load_val = 8'h00;
        steps(2);
        check_eq("rst_count", 32'(count),   32'h0);
        check_eq("rst_disp",  32'(display), 32'h03);
        check_eq("rst_ctrl",  32'(ctrl),    32'h2);

        // Count up from reset: one step every TICK_DIV clocks.
        rst_n = 1'b1;
        steps(4);
        check_eq("up_1", 32'(count), 32'h01);
        steps(4);
        check_eq("up_2", 32'(count), 32'h02);

        // Wrap FE -> FF -> 00 with tc on the wrap.
        load = 1'b1; load_val = 8'hFE;
        step();
        load = 1'b0;
        check_eq("ld_fe", 32'(count), 32'hFE);
        steps(4);
        check_eq("wrap_ff", 32'(count), 32'hFF);
        check_eq("wrap_ff_tc", 32'(tc), 32'h0);
        steps(4);
        check_eq("wrap_00", 32'(count), 32'h00);
        check_eq("wrap_tc", 32'(tc), 32'h1);
        step();
        check_eq("wrap_tc_clr", 32'(tc), 32'h0);

        // Saturate at 00 counting down, then wrap to FF.
        load = 1'b1; load_val = 8'h00;
        step();
        load = 1'b0; up = 1'b0; wrap = 1'b0;
        for (int t = 0; t < 3; t++) begin
            steps(4);
            check_eq("sat_tc", 32'(tc), 32'h1);
        end
        check_eq("sat_00", 32'(count), 32'h00);
        wrap = 1'b1;
        steps(4);
        check_eq("dn_wrap", 32'(count), 32'hFF);

        // Scan 3A: digit select and glyph always agree.
        load = 1'b1; load_val = 8'h3A; en = 1'b0;
        step();
        load = 1'b0;
        steps(2);
        for (int i = 0; i < 8; i++) begin
            step();
            if (ctrl == 2'b10) check_eq("scan_a", 32'(display), 32'h11);
            else               check_eq("scan_3", 32'(display), 32'h0D);
        end

        // Load coinciding with a tick restarts the prescaler.
        en = 1'b1; up = 1'b1;
        for (int i = 0; i < TICK_DIV && m_presc != TICK_DIV - 1; i++) step();
        load = 1'b1; load_val = 8'h55;
        step();
        load = 1'b0;
        check_eq("lt_55", 32'(count), 32'h55);
        steps(3);
        check_eq("lt_hold", 32'(count), 32'h55);
        step();
        check_eq("lt_56", 32'(count), 32'h56);

        // Reset mid-count.
        load = 1'b1; load_val = 8'h77;
        step();
        load = 1'b0;
        steps(2);
        rst_n = 1'b0;
        step();
        check_eq("mrst_count", 32'(count),   32'h0);
        check_eq("mrst_tc",    32'(tc),      32'h0);
        check_eq("mrst_ctrl",  32'(ctrl),    32'h2);
        check_eq("mrst_disp",  32'(display), 32'h03);
        rst_n = 1'b1;
        steps(3);
        check_eq("mrst_wait", 32'(count), 32'h0);
        step();
        check_eq("mrst_first", 32'(count), 32'h1);

        // Randomized traffic, biased toward the boundaries.
        pick = '{8'h00, 8'hFF, 8'h01, 8'hFE, 8'h80};
        for (int i = 0; i < 1500; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            load  = ($urandom_range(0, 24) == 0);
            en    = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) up   = $urandom_range(0, 1) != 0;
            if ($urandom_range(0, 7) == 0) wrap = $urandom_range(0, 1) != 0;
            if ($urandom_range(0, 1) == 0) load_val = pick[$urandom_range(0, 4)];
            else                           load_val = 8'($urandom_range(0, 255));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/scan_updown_counter.md
Name: scan_updown_counter

Overview:
- Parametrised successor to the single-digit binary down counter.
- WIDTH-bit counter stepping once per prescaler tick; runtime-selectable up/down direction, wrap or saturate, synchronous parallel load.
- Value shown in hex on a multiplexed NUM_DIGITS seven-segment display.
- Sits at board top level between the clock/reset pins and the segment/digit-select pins.

Parameters:
WIDTH, 8, counter width in bits; must be a multiple of 4.
NUM_DIGITS, WIDTH/4, digits scanned; digit i shows count[4i+3:4i].
TICK_DIV, 25_000_000, clk cycles per count tick; must be >= 2.
SCAN_DIV, 100_000, clk cycles per digit-scan step; must be >= 1.

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
en  in  1  count enable, sampled on tick cycles
up  in  1  1 = count up, 0 = count down
wrap  in  1  1 = wrap at boundary, 0 = saturate
load  in  1  synchronous load strobe
load_val  in  WIDTH  value for load
count  out  WIDTH  current count, registered
tc  out  1  terminal-count pulse, one clk wide
display  out  8  segments {a,b,c,d,e,f,g,dp}, active-low, registered
ctrl  out  NUM_DIGITS  digit selects, active-low one-hot, registered

Behaviour:
- Reset when rst_n=0 at a clk edge, regardless of other inputs:
  - count=0, tc=0, prescaler=0, scan counter=0, digit index=0.
  - ctrl has only bit0 low; display=8'b0000_0011 (hex 0, dp off).
- Prescaler: counts 0..TICK_DIV-1 and wraps; internal tick is high during the cycle it equals TICK_DIV-1.
- Priority per edge: reset > load > tick step.
- Load:
  - load=1 gives count<=load_val and prescaler<=0 on the next edge, with no tick dependence.
  - tc<=0 on a load edge.
- Step: on a tick cycle with en=1 and load=0:
  - up=1: count<MAX gives count+1. count==MAX gives 0 if wrap=1, otherwise holds MAX.
  - up=0: count>0 gives count-1. count==0 gives MAX if wrap=1, otherwise holds 0.
  - MAX = 2^WIDTH-1.
- tc: registered, high for exactly one clk on the edge a step is attempted from the boundary in the current direction (MAX when up, 0 when down), whether it wraps or saturates. Low otherwise.
- en=0 or a non-tick cycle: count holds, tc=0. up/wrap changes take effect on the next tick only.
- Scan:
  - Scan counter counts 0..SCAN_DIV-1.
  - At SCAN_DIV-1 the digit index advances, NUM_DIGITS-1 wrapping to 0.
  - ctrl bit[index] is low, all others high.
- display and ctrl are registered from the same index and the current count on the same edge. No cycle exists in which ctrl and display belong to different digits.
- display latency: one clk after a count or index change.
- Hex segment patterns are active-low 0-F (0=0000_0011, 1=1001_1111, 8=0000_0001, F=0111_0001); dp is always 1.
- NUM_DIGITS=1: index is constant 0 and ctrl is constantly 0.
- Reset mid-count or mid-scan: all state returns to the reset values on that edge with no partial updates; counting restarts a full TICK_DIV later.

Decomposition:
- Package seg7_pkg:
  - Function hex_to_seg (4-bit in, 8-bit active-low out).
  - Constants SEG_BLANK=8'hFF and SEG_ZERO=8'h03.
  - Typedef for direction/mode encodings.
- Sub-module seg7_decoder: combinational wrapper of hex_to_seg, instantiated once for the selected nibble.
- Prescaler, counter, and scan logic stay in the top of the block.

Test Plan:
(Bench parameters: WIDTH=8, TICK_DIV=4, SCAN_DIV=2.)
- Reset release, en=1, up=1, wrap=1: count advances 0 to 1 to 2 every 4 clk. tc stays 0. display=0000_0011 during reset.
- load_val=8'hFE, then up=1, wrap=1: count FE, then FF, then 00. tc high exactly one clk on the FF to 00 edge.
- Count=00, up=0, wrap=0: count holds 00 across 3 ticks, with tc pulsing once per tick. With wrap=1, the next tick gives FF.
- Scan with count=8'h3A: ctrl alternates 10/01 every 2 clk. display=0001_0001 (A) with ctrl=10 and 0000_1101 (3) with ctrl=01; the pair never mismatches.
- load and tick in the same cycle with load_val=8'h55: count=55 and the prescaler restarts, so the next step is exactly 4 clk later.
- rst_n=0 for one edge mid-count at 8'h77: the next cycle shows count=0, tc=0, ctrl=10, display=0000_0011.
